ika9958_cen_gen: RTL and testbench

Parametrised clock-enable generator, the successor to the fixed /2 and /4 divider in reset and clock control. It derives NTAP binary-divided clock taps from the master clock and emits one-tick positive- and negative-edge enable pulses per tap. It drives the open-drain DHCLK/DLCLK pins and genlocks its phase to an external DLCLK through a lock state machine with a watchdog. It sits at the top of the clock tree and feeds every phiH/phiL-enabled consumer.

---
 rtl/ika9958_pkg.sv | 13 +
 rtl/ika9958_genlock_sync.sv | 29 ++
 rtl/ika9958_cen_gen.sv | 150 +++++++++++++++
 tb/tb_ika9958_cen_gen.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ika9958_pkg.sv
// Shared types for the IKA9958 clock tree: genlock state encoding and
// the width of the lock match counter.
package IKA9958_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } lock_st_t;

  localparam int MC_W = 4;

endpackage

// File: rtl/ika9958_genlock_sync.sv
// Three-stage tick-sampled synchroniser for the external DLCLK pin with
// falling-edge detect on the two oldest stages.
module ika9958_genlock_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic i_DLCLK_n,
  input  logic enable,
  output logic o_edge
);

  // sync_q[0] is s1 (newest sample), sync_q[2] is s3 (oldest)
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = sync_q;
    if (tick) sync_d = {sync_q[1:0], i_DLCLK_n};
  end

  // NOTE: clocked state is written only with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 3'b111;
    else        sync_q <= sync_d;
  end

  assign o_edge = sync_q[2] & ~sync_q[1] & enable;

endmodule

// File: rtl/ika9958_cen_gen.sv
// Clock-enable generator: binary phase counter with per-tap rise/fall enables,
// DHCLK/DLCLK open-drain drivers and a genlock FSM with watchdog.
module ika9958_cen_gen
  import IKA9958_pkg::*;
#(
  parameter int CM         = 0,
  parameter int NTAP       = 2,
  parameter int LOCK_PHASE = 3,
  parameter int LOCK_CNT   = 4
) (
  input  logic            i_XTAL1,
  input  logic            i_RST_n,
  input  logic            i_XTAL_NCEN,
  input  logic            i_DLCLK_n,
  input  logic            i_GENLOCK_EN,
  output logic [NTAP-1:0] o_PCEN,
  output logic [NTAP-1:0] o_NCEN,
  output logic [NTAP-1:0] o_CLKLVL,
  output logic            o_DHCLK_n,
  output logic            o_DLCLK_n,
  output logic            o_LOCKED,
  output logic            o_LOCK_ERR
);

  localparam int              WDW     = NTAP + 2;
  localparam logic [NTAP-1:0] PH_LOCK = NTAP'(LOCK_PHASE);
  localparam logic [NTAP-1:0] PH_CORR = NTAP'(LOCK_PHASE + 1);
  localparam logic [WDW-1:0]  WD_TO   = WDW'(1) << (NTAP + 1);
  localparam logic [MC_W-1:0] MC_LOCK = MC_W'(LOCK_CNT);

  logic tick;
  assign tick = (CM == 0) ? 1'b1 : i_XTAL_NCEN;

  logic sync_edge;

  ika9958_genlock_sync u_sync (
    .clk       (i_XTAL1),
    .rst_n     (i_RST_n),
    .tick      (tick),
    .i_DLCLK_n (i_DLCLK_n),
    .enable    (i_GENLOCK_EN),
    .o_edge    (sync_edge)
  );

  logic [NTAP-1:0] cnt_q, cnt_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic [MC_W-1:0] mc_q, mc_d;
  lock_st_t        st_q, st_d;
  logic            locked_q, locked_d;
  logic            lock_err_q, lock_err_d;

  logic            dl_edge, in_phase, corr, timeout;
  logic [WDW-1:0]  wd_inc;
  logic [NTAP-1:0] pcen_raw, ncen_raw;

  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    dl_edge  = sync_edge & tick;
    in_phase = (cnt_q == PH_LOCK);
    corr     = dl_edge & ~in_phase;
    wd_inc   = wd_q + 1'b1;
    timeout  = tick & ~dl_edge & (wd_inc == WD_TO);

    cnt_d = cnt_q;
    if (tick) cnt_d = corr ? PH_CORR : cnt_q + 1'b1;

    wd_d = wd_q;
    if (tick) wd_d = dl_edge ? '0 : wd_inc;

    st_d       = st_q;
    mc_d       = mc_q;
    lock_err_d = 1'b0;
    if (!i_GENLOCK_EN) begin
      st_d = FREE;
      mc_d = '0;
      wd_d = '0;
    end else if (dl_edge) begin
      case (st_q)
        FREE: begin
          st_d = ACQ;
          mc_d = in_phase ? MC_W'(1) : '0;
        end
        ACQ: begin
          if (in_phase) begin
            mc_d = mc_q + 1'b1;
            if (mc_d >= MC_LOCK) st_d = LOCKED;
          end else begin
            mc_d = '0;
          end
        end
        LOCKED: begin
          if (!in_phase) begin
            st_d       = ACQ;
            mc_d       = '0;
            lock_err_d = 1'b1;
          end
        end
        default: st_d = FREE;
      endcase
    end else if (timeout && st_q != FREE) begin
      // Watchdog drops lock but leaves the counter phase alone
      st_d       = FREE;
      mc_d       = '0;
      lock_err_d = (st_q == LOCKED);
    end

    locked_d = (st_d == LOCKED);
  end

  always_comb begin
    logic run;
    run      = tick;
    pcen_raw = '0;
    ncen_raw = '0;
    for (int k = 0; k < NTAP; k++) begin
      pcen_raw[k] = run & ~cnt_q[k];
      ncen_raw[k] = run & cnt_q[k];
      run         = run & cnt_q[k];
    end
  end

  always_ff @(posedge i_XTAL1 or negedge i_RST_n) begin
    if (!i_RST_n) begin
      cnt_q      <= '0;
      wd_q       <= '0;
      mc_q       <= '0;
      st_q       <= FREE;
      locked_q   <= 1'b0;
      lock_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      wd_q       <= wd_d;
      mc_q       <= mc_d;
      st_q       <= st_d;
      locked_q   <= locked_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Enables vanish on a phase-correction tick and throughout reset
  assign o_PCEN     = pcen_raw & {NTAP{i_RST_n & ~corr}};
  assign o_NCEN     = ncen_raw & {NTAP{i_RST_n & ~corr}};
  assign o_CLKLVL   = cnt_q;
  assign o_DHCLK_n  = ~cnt_q[0];
  assign o_DLCLK_n  = ~cnt_q[NTAP-1] | i_GENLOCK_EN;
  assign o_LOCKED   = locked_q;
  assign o_LOCK_ERR = lock_err_q;

endmodule

// File: tb/tb_ika9958_cen_gen.sv
// Directed bench for ika9958_cen_gen (NTAP=2, LOCK_PHASE=3, LOCK_CNT=4):
// free run, CM=1 ticking, genlock acquisition, slip, timeout, reset, disable.
module tb_ika9958_cen_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ncen;
  logic       gl, pin;
  logic       gl1, pin1;

  logic [1:0] pcen0, ncen0, lvl0;
  logic       dh0, dl0, lk0, er0;
  logic [1:0] pcen1, ncen1, lvl1;
  logic       dh1, dl1, lk1, er1;

  int total = 0;
  int bad   = 0;

  logic [1:0] pt [4];
  logic [1:0] nt [4];
  logic       dt [4];

  always #5 clk = ~clk;

  ika9958_cen_gen #(.CM(0), .NTAP(2), .LOCK_PHASE(3), .LOCK_CNT(4)) dut0 (
    .i_XTAL1      (clk),
    .i_RST_n      (rst_n),
    .i_XTAL_NCEN  (ncen),
    .i_DLCLK_n    (pin),
    .i_GENLOCK_EN (gl),
    .o_PCEN       (pcen0),
    .o_NCEN       (ncen0),
    .o_CLKLVL     (lvl0),
    .o_DHCLK_n    (dh0),
    .o_DLCLK_n    (dl0),
    .o_LOCKED     (lk0),
    .o_LOCK_ERR   (er0)
  );

  ika9958_cen_gen #(.CM(1), .NTAP(2), .LOCK_PHASE(3), .LOCK_CNT(4)) dut1 (
    .i_XTAL1      (clk),
    .i_RST_n      (rst_n),
    .i_XTAL_NCEN  (ncen),
    .i_DLCLK_n    (pin1),
    .i_GENLOCK_EN (gl1),
    .o_PCEN       (pcen1),
    .o_NCEN       (ncen1),
    .o_CLKLVL     (lvl1),
    .o_DHCLK_n    (dh1),
    .o_DLCLK_n    (dl1),
    .o_LOCKED     (lk1),
    .o_LOCK_ERR   (er1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic next_clk();
    @(posedge clk);
    #1;
  endtask

  // Four DLCLK periods aligned so each detected edge lands on cnt=3.
  // Starts with dut0 at cnt=0; err_first is the LOCK_ERR level expected
  // on the very first cycle (a pulse left over from a preceding slip).
  task automatic lock_run(input logic err_first);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 4; c++) begin
        pin = (c == 1 || c == 2) ? 1'b0 : 1'b1;
        #1;
        check("acq_cnt",  32'(lvl0),  32'(c));
        check("acq_pcen", 32'(pcen0), 32'(pt[c]));
        check("acq_ncen", 32'(ncen0), 32'(nt[c]));
        check("acq_dl",   32'(dl0),   32'd1);
        check("acq_lk",   32'(lk0),   32'd0);
        check("acq_err",  32'(er0),   (p == 0 && c == 0) ? 32'(err_first) : 32'd0);
        next_clk();
      end
    end
  endtask

  initial begin
    int c1;
    pt = '{2'b01, 2'b10, 2'b01, 2'b00};
    nt = '{2'b00, 2'b01, 2'b00, 2'b11};
    dt = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; ncen = 1'b0; gl = 1'b0; pin = 1'b1; gl1 = 1'b0; pin1 = 1'b1;

    // Reset state, sampled after a clock edge has passed under reset
    #7;
    check("rst_cnt",  32'(lvl0),  32'd0);
    check("rst_pcen", 32'(pcen0), 32'd0);
    check("rst_ncen", 32'(ncen0), 32'd0);
    check("rst_dh",   32'(dh0),   32'd1);
    check("rst_dl",   32'(dl0),   32'd1);
    check("rst_lk",   32'(lk0),   32'd0);
    check("rst_err",  32'(er0),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CM=0 free run: 0,1,2,3,0,... with tap enables per table
    for (int i = 0; i < 8; i++) begin
      #1;
      check("free_cnt",  32'(lvl0),  32'(i % 4));
      check("free_pcen", 32'(pcen0), 32'(pt[i % 4]));
      check("free_ncen", 32'(ncen0), 32'(nt[i % 4]));
      check("free_dh",   32'(dh0),   (i % 2 == 0) ? 32'd1 : 32'd0);
      check("free_dl",   32'(dl0),   32'(dt[i % 4]));
      check("cm1_idle",  32'(pcen1 | ncen1), 32'd0);
      next_clk();
    end

    // CM=1: tick on every third clock only, pulses one clock wide
    c1 = 0;
    for (int i = 0; i < 12; i++) begin
      ncen = (i % 3 == 2);
      #1;
      check("cm1_cnt",  32'(lvl1),  32'(c1));
      check("cm1_pcen", 32'(pcen1), ncen ? 32'(pt[c1]) : 32'd0);
      check("cm1_ncen", 32'(ncen1), ncen ? 32'(nt[c1]) : 32'd0);
      next_clk();
      if (ncen) c1 = (c1 + 1) % 4;
    end
    ncen = 1'b0;

    // Genlock acquisition: in-phase edges, lock after the 4th
    gl = 1'b1;
    lock_run(1'b0);
    #1;
    check("lock_set", 32'(lk0), 32'd1);

    // Slip: edge one tick early, detected at cnt=2
    for (int c = 0; c < 3; c++) begin
      pin = 1'b0;
      #1;
      check("slip_cnt", 32'(lvl0), 32'(c));
      check("slip_lk",  32'(lk0),  32'd1);
      check("slip_pcen", 32'(pcen0), (c == 2) ? 32'd0 : 32'(pt[c]));
      check("slip_ncen", 32'(ncen0), (c == 2) ? 32'd0 : 32'(nt[c]));
      next_clk();
    end
    lock_run(1'b1);
    #1;
    check("relock", 32'(lk0), 32'd1);

    // DLCLK stops: 8 edgeless ticks then drop to FREE with one error pulse
    pin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("wd_cnt", 32'(lvl0), 32'(i % 4));
      check("wd_lk",  32'(lk0),  32'd1);
      check("wd_err", 32'(er0),  32'd0);
      next_clk();
    end
    #1;
    check("to_lk",   32'(lk0),   32'd0);
    check("to_err",  32'(er0),   32'd1);
    check("to_cnt",  32'(lvl0),  32'd0);
    check("to_pcen", 32'(pcen0), 32'd1);
    next_clk();
    for (int c = 1; c < 4; c++) begin
      #1;
      check("post_cnt", 32'(lvl0), 32'(c));
      check("post_err", 32'(er0),  32'd0);
      next_clk();
    end

    // Reset while locked, mid-cycle
    lock_run(1'b0);
    for (int c = 0; c < 2; c++) begin
      pin = (c == 1) ? 1'b0 : 1'b1;
      next_clk();
    end
    #1;
    check("pre_rst_cnt", 32'(lvl0), 32'd2);
    rst_n = 1'b0;
    pin   = 1'b1;
    #1;
    check("mrst_cnt",  32'(lvl0),  32'd0);
    check("mrst_pcen", 32'(pcen0), 32'd0);
    check("mrst_ncen", 32'(ncen0), 32'd0);
    check("mrst_dh",   32'(dh0),   32'd1);
    check("mrst_dl",   32'(dl0),   32'd1);
    check("mrst_lk",   32'(lk0),   32'd0);
    check("mrst_err",  32'(er0),   32'd0);
    next_clk();
    check("hold_cnt",  32'(lvl0),  32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("rel_cnt",  32'(lvl0),  32'(i % 4));
      check("rel_pcen", 32'(pcen0), 32'(pt[i % 4]));
      check("rel_ncen", 32'(ncen0), 32'(nt[i % 4]));
      check("rel_lk",   32'(lk0),   32'd0);
      next_clk();
    end

    // Genlock disable drops lock silently and releases DLCLK drive
    lock_run(1'b0);
    gl  = 1'b0;
    pin = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("dis_dl",  32'(dl0), 32'(dt[c]));
      check("dis_lk",  32'(lk0), (c == 0) ? 32'd1 : 32'd0);
      check("dis_err", 32'(er0), 32'd0);
      next_clk();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
